// File: rtl/vip_timing_pattern_gen.sv
// Synthetic video source: frame timing plus selectable grey test pattern on the
// per-image stream interface, used in place of the sensor path during bring-up.
module vip_timing_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CHECK_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_en,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  gray_const,
  output logic        post_img_vsync,
  output logic        post_img_href,
  output logic        post_img_de,
  output logic [7:0]  post_img_gray,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int H_AS    = H_SYNC + H_BP;
  localparam int H_AE    = H_AS + H_ACTIVE;
  localparam int V_AS    = V_SYNC + V_BP;
  localparam int V_AE    = V_AS + V_ACTIVE;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_latch;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic [1:0]      r_pat_sel;
  logic [7:0]      r_gray_const;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_frame_end;
  logic            w_av;
  logic            w_ah;
  logic            w_vs;
  logic [7:0]      w_x;
  logic [7:0]      w_y;
  logic [7:0]      w_pix;

  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_frame_end = (r_state == S_RUN) && pix_en && w_h_last && w_v_last;
  assign w_vs        = (32'(r_v_cnt) < V_SYNC);
  assign w_av        = (32'(r_v_cnt) >= V_AS) && (32'(r_v_cnt) < V_AE);
  assign w_ah        = (32'(r_h_cnt) >= H_AS) && (32'(r_h_cnt) < H_AE);

  // Only the low 8 bits of the coordinates ever reach the pattern.
  assign w_x = 8'(r_h_cnt) - 8'(H_AS);
  assign w_y = 8'(r_v_cnt) - 8'(V_AS);

  always_comb begin
    w_pix = 8'h00;
    case (r_pat_sel)
      2'd0:    w_pix = w_x;
      2'd1:    w_pix = w_y;
      2'd2:    w_pix = (w_x[CHECK_LOG2] ^ w_y[CHECK_LOG2]) ? 8'hFF : 8'h00;
      default: w_pix = r_gray_const;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // enable only matters in IDLE or on the last slot of a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_RUN;
          w_latch     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_frame_end) begin
          if (enable) w_latch     = 1'b1;
          else        w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat_sel    <= 2'd0;
      r_gray_const <= 8'h00;
    end else if (w_latch) begin
      r_pat_sel    <= pattern_sel;
      r_gray_const <= gray_const;
    end
  end

  // Output register: one cycle behind the counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_img_vsync <= 1'b0;
      post_img_href  <= 1'b0;
      post_img_de    <= 1'b0;
      post_img_gray  <= 8'h00;
      frame_done     <= 1'b0;
      frame_cnt      <= 16'd0;
    end else begin
      frame_done <= w_frame_end;
      if (w_frame_end) frame_cnt <= frame_cnt + 16'd1;
      if (r_state == S_RUN) begin
        post_img_vsync <= w_vs;
        post_img_href  <= w_av && w_ah;
        post_img_de    <= w_av && w_ah && pix_en;
        if (w_av && w_ah && pix_en) post_img_gray <= w_pix;
      end else begin
        post_img_vsync <= 1'b0;
        post_img_href  <= 1'b0;
        post_img_de    <= 1'b0;
      end
    end
  end

endmodule
